// File: rtl/aer_bus_arbiter.sv
// aer_bus_arbiter: shares the AER broadcast bus between NUM_SRC event sources.
// Round-robin grant, four-phase handshake toward sources and arrays, ack
// aggregation over a latched array-enable mask, and a per-phase watchdog
// that parks the arbiter in a sticky error state until cleared.
module aer_bus_arbiter #(
    parameter int NUM_SRC     = 3,
    parameter int TIME_W      = 8,
    parameter int ADDR_W      = 10,
    parameter int NUM_ARRAYS  = 16,
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 16,
    localparam int GID_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                      local_clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        i_src_req,
    input  logic [NUM_SRC*TIME_W-1:0] i_src_time,
    input  logic [NUM_SRC*ADDR_W-1:0] i_src_addr,
    output logic [NUM_SRC-1:0]        o_src_ack,
    input  logic [NUM_ARRAYS-1:0]     i_array_en,
    input  logic [NUM_ARRAYS-1:0]     i_array_ack,
    output logic                      o_aer_req,
    output logic [TIME_W-1:0]         o_aer_time,
    output logic [ADDR_W-1:0]         o_aer_addr,
    output logic [GID_W-1:0]          o_grant_id,
    output logic                      o_busy,
    output logic                      o_timeout_err,
    input  logic                      i_err_clear,
    output logic [CNT_W-1:0]          o_event_count
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RELEASE, S_ERR} state_t;

    typedef struct packed {
        logic [TIME_W-1:0] ts;
        logic [ADDR_W-1:0] addr;
    } aer_ev_t;

    // Per-source event view, unpacked from the flat input buses.
    aer_ev_t src_ev [NUM_SRC];

    generate
        for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
            assign src_ev[k] = {i_src_time[k*TIME_W +: TIME_W], i_src_addr[k*ADDR_W +: ADDR_W]};
        end
    endgenerate

    state_t                state_q, state_d;
    logic [GID_W-1:0]      rr_q, rr_d;
    logic [GID_W-1:0]      gnt_q, gnt_d;
    logic [NUM_ARRAYS-1:0] en_lat_q, en_lat_d;
    aer_ev_t               ev_q, ev_d;
    logic                  req_q, req_d;
    logic [NUM_SRC-1:0]    ack_q, ack_d;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [WD_W-1:0]       wd_q, wd_d;

    logic [WD_W-1:0]       wd_inc;
    logic                  wd_hit;
    logic                  agg_ack, agg_idle;
    logic                  pick_vld;
    logic [GID_W-1:0]      pick_id;
    logic [GID_W:0]        sum;
    logic [GID_W-1:0]      idx;

    // Disabled arrays count as acked and as idle; an empty mask completes on its own.
    assign agg_ack  = &(i_array_ack | ~en_lat_q);
    assign agg_idle = ~|(i_array_ack & en_lat_q);

    assign wd_inc = wd_q + 1'b1;
    assign wd_hit = (wd_inc == WD_W'(TIMEOUT_CYC));

    // Round-robin pick: first requester at or above the rr pointer, wrapping.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        sum      = '0;
        idx      = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            sum = {1'b0, rr_q} + (GID_W+1)'(i);
            if (sum >= (GID_W+1)'(NUM_SRC))
                sum = sum - (GID_W+1)'(NUM_SRC);
            idx = sum[GID_W-1:0];
            if (!pick_vld && i_src_req[idx]) begin
                pick_vld = 1'b1;
                pick_id  = idx;
            end
        end
    end

    // Next-state and registered-output logic for the bus FSM.
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        gnt_d    = gnt_q;
        en_lat_d = en_lat_q;
        ev_d     = ev_q;
        req_d    = req_q;
        ack_d    = ack_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        wd_d     = wd_q;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    gnt_d    = pick_id;
                    ev_d     = src_ev[pick_id];
                    en_lat_d = i_array_en;
                    req_d    = 1'b1;
                    wd_d     = '0;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // A completing ack wins over a watchdog expiry in the same cycle.
                if (agg_ack) begin
                    req_d        = 1'b0;
                    ack_d        = '0;
                    ack_d[gnt_q] = 1'b1;
                    wd_d         = '0;
                    state_d      = S_RELEASE;
                end else if (wd_hit) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end else begin
                    wd_d = wd_inc;
                end
            end
            S_RELEASE: begin
                if (agg_idle && !i_src_req[gnt_q]) begin
                    ack_d   = '0;
                    cnt_d   = cnt_q + 1'b1;
                    rr_d    = (gnt_q == GID_W'(NUM_SRC - 1)) ? '0 : gnt_q + 1'b1;
                    state_d = S_IDLE;
                end else if (wd_hit) begin
                    ack_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end else begin
                    wd_d = wd_inc;
                end
            end
            S_ERR: begin
                if (i_err_clear) begin
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything including mid-transaction.
    always_ff @(posedge local_clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rr_q     <= '0;
            gnt_q    <= '0;
            en_lat_q <= '0;
            ev_q     <= '0;
            req_q    <= 1'b0;
            ack_q    <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            gnt_q    <= gnt_d;
            en_lat_q <= en_lat_d;
            ev_q     <= ev_d;
            req_q    <= req_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            wd_q     <= wd_d;
        end
    end

    assign o_aer_req     = req_q;
    assign o_aer_time    = ev_q.ts;
    assign o_aer_addr    = ev_q.addr;
    assign o_src_ack     = ack_q;
    assign o_grant_id    = gnt_q;
    assign o_timeout_err = err_q;
    assign o_event_count = cnt_q;
    assign o_busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_aer_bus_arbiter.sv
// Bench for aer_bus_arbiter: directed handshake scenarios plus randomized
// traffic checked against a cycle-level model of the arbitration rules.
module tb_aer_bus_arbiter;

    localparam int NUM_SRC     = 3;
    localparam int TIME_W      = 8;
    localparam int ADDR_W      = 10;
    localparam int NUM_ARRAYS  = 16;
    localparam int TIMEOUT_CYC = 10;
    localparam int CNT_W       = 16;
    localparam int GID_W       = 2;

    logic                      local_clk;
    logic                      rst;
    logic [NUM_SRC-1:0]        i_src_req;
    logic [NUM_SRC*TIME_W-1:0] i_src_time;
    logic [NUM_SRC*ADDR_W-1:0] i_src_addr;
    logic [NUM_SRC-1:0]        o_src_ack;
    logic [NUM_ARRAYS-1:0]     i_array_en;
    logic [NUM_ARRAYS-1:0]     i_array_ack;
    logic                      o_aer_req;
    logic [TIME_W-1:0]         o_aer_time;
    logic [ADDR_W-1:0]         o_aer_addr;
    logic [GID_W-1:0]          o_grant_id;
    logic                      o_busy;
    logic                      o_timeout_err;
    logic                      i_err_clear;
    logic [CNT_W-1:0]          o_event_count;

    int checks = 0;
    int errors = 0;
    int mptr = 0;          // model round-robin pointer
    int model_count = 0;   // model delivered-event count
    int grant_log[$];

    aer_bus_arbiter #(
        .NUM_SRC(NUM_SRC), .TIME_W(TIME_W), .ADDR_W(ADDR_W),
        .NUM_ARRAYS(NUM_ARRAYS), .TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)
    ) dut (
        .local_clk(local_clk), .rst(rst),
        .i_src_req(i_src_req), .i_src_time(i_src_time), .i_src_addr(i_src_addr),
        .o_src_ack(o_src_ack), .i_array_en(i_array_en), .i_array_ack(i_array_ack),
        .o_aer_req(o_aer_req), .o_aer_time(o_aer_time), .o_aer_addr(o_aer_addr),
        .o_grant_id(o_grant_id), .o_busy(o_busy), .o_timeout_err(o_timeout_err),
        .i_err_clear(i_err_clear), .o_event_count(o_event_count)
    );

    initial local_clk = 1'b0;
    always #5 local_clk = ~local_clk;

    task automatic tick();
        @(negedge local_clk);
    endtask

    task automatic set_src(input int k, input logic [TIME_W-1:0] t, input logic [ADDR_W-1:0] a);
        i_src_time[k*TIME_W +: TIME_W] = t;
        i_src_addr[k*ADDR_W +: ADDR_W] = a;
    endtask

    function automatic int rr_pick(input logic [NUM_SRC-1:0] req, input int ptr);
        int idx;
        for (int i = 0; i < NUM_SRC; i++) begin
            idx = (ptr + i) % NUM_SRC;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [NUM_SRC-1:0] onehot(input int k);
        logic [NUM_SRC-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({o_aer_req, o_src_ack, o_aer_time, o_aer_addr, o_grant_id, o_busy, o_timeout_err, o_event_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b ack=%b id=%0d busy=%b err=%b cnt=%0d, all must be 0",
                     o_aer_req, o_src_ack, o_grant_id, o_busy, o_timeout_err, o_event_count);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (o_busy !== 1'b0 || o_event_count !== '0) begin
            errors++;
            $display("FAIL reset_release: busy=%b cnt=%0d expected 0/0", o_busy, o_event_count);
        end
        mptr = 0;
        model_count = 0;
    endtask

    task automatic test_single();
        set_src(1, 8'h14, 10'd37);
        i_array_en  = 16'h00FF;
        i_array_ack = '0;
        i_src_req   = 3'b010;
        tick();
        checks++;
        if ({o_aer_req, o_grant_id, o_aer_time, o_aer_addr, o_src_ack, o_busy} !== {1'b1, 2'd1, 8'h14, 10'd37, 3'b000, 1'b1}) begin
            errors++;
            $display("FAIL single_issue: req=%b id=%0d time=%h addr=%0d ack=%b, expected 1/1/14/37/000",
                     o_aer_req, o_grant_id, o_aer_time, o_aer_addr, o_src_ack);
        end
        tick();
        // Disabled arrays ack but enabled array 7 is still missing.
        i_array_ack = 16'hFF7F;
        tick();
        checks++;
        if (o_aer_req !== 1'b1 || o_src_ack !== 3'b000 || o_aer_time !== 8'h14 || o_aer_addr !== 10'd37) begin
            errors++;
            $display("FAIL single_partial_ack: req=%b ack=%b time=%h addr=%0d, expected 1/000/14/37",
                     o_aer_req, o_src_ack, o_aer_time, o_aer_addr);
        end
        i_array_ack = 16'h00FF;
        tick();
        checks++;
        if (o_aer_req !== 1'b0 || o_src_ack !== 3'b010) begin
            errors++;
            $display("FAIL single_src_ack: req=%b ack=%b, expected 0/010", o_aer_req, o_src_ack);
        end
        i_src_req = 3'b000;
        tick();
        checks++;
        if (o_src_ack !== 3'b010) begin
            errors++;
            $display("FAIL single_hold_arrays: ack=%b expected 010 while arrays still ack", o_src_ack);
        end
        i_array_ack = '0;
        tick();
        checks++;
        if (o_src_ack !== 3'b000 || o_event_count !== 16'd1 || o_busy !== 1'b0 || o_grant_id !== 2'd1) begin
            errors++;
            $display("FAIL single_done: ack=%b cnt=%0d busy=%b id=%0d, expected 000/1/0/1",
                     o_src_ack, o_event_count, o_busy, o_grant_id);
        end
        mptr = 2;
        model_count = 1;
    endtask

    task automatic test_partial_ack();
        set_src(2, 8'h55, 10'd513);
        i_array_en = 16'h0001;
        i_src_req  = 3'b100;
        tick();
        checks++;
        if (o_aer_req !== 1'b1 || o_grant_id !== 2'd2) begin
            errors++;
            $display("FAIL partial_issue: req=%b id=%0d expected 1/2", o_aer_req, o_grant_id);
        end
        // Enable change mid-ISSUE must be ignored; arrays 1-15 never ack.
        i_array_en = 16'hFFFF;
        tick();
        checks++;
        if (o_aer_req !== 1'b1) begin
            errors++;
            $display("FAIL partial_wait: req=%b expected 1", o_aer_req);
        end
        i_array_ack = 16'h0001;
        tick();
        checks++;
        if (o_aer_req !== 1'b0 || o_src_ack !== 3'b100) begin
            errors++;
            $display("FAIL partial_ack: req=%b ack=%b expected 0/100", o_aer_req, o_src_ack);
        end
        i_src_req   = 3'b000;
        i_array_ack = '0;
        tick();
        checks++;
        if (o_src_ack !== 3'b000 || o_event_count !== 16'd2) begin
            errors++;
            $display("FAIL partial_done: ack=%b cnt=%0d expected 000/2", o_src_ack, o_event_count);
        end
        mptr = 0;
        model_count = 2;
    endtask

    task automatic test_empty_mask();
        set_src(0, 8'h7E, 10'd900);
        i_array_en  = '0;
        i_array_ack = NUM_ARRAYS'($urandom);
        i_src_req   = 3'b001;
        tick();
        checks++;
        if (o_aer_req !== 1'b1 || o_grant_id !== 2'd0) begin
            errors++;
            $display("FAIL empty_issue: req=%b id=%0d expected 1/0", o_aer_req, o_grant_id);
        end
        i_array_ack = NUM_ARRAYS'($urandom);
        tick();
        checks++;
        if (o_aer_req !== 1'b0 || o_src_ack !== 3'b001) begin
            errors++;
            $display("FAIL empty_ack: req=%b ack=%b expected 0/001", o_aer_req, o_src_ack);
        end
        i_array_ack = NUM_ARRAYS'($urandom);
        tick();
        checks++;
        if (o_src_ack !== 3'b001) begin
            errors++;
            $display("FAIL empty_hold_req: ack=%b expected 001 while source holds req", o_src_ack);
        end
        i_src_req   = 3'b000;
        i_array_ack = NUM_ARRAYS'($urandom);
        tick();
        checks++;
        if (o_src_ack !== 3'b000 || o_event_count !== 16'd3 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL empty_done: ack=%b cnt=%0d busy=%b expected 000/3/0", o_src_ack, o_event_count, o_busy);
        end
        i_array_ack = '0;
        mptr = 1;
        model_count = 3;
    endtask

    task automatic test_timeout();
        int exp;
        set_src(1, 8'h33, 10'd99);
        i_array_en = 16'h0003;
        i_src_req  = 3'b010;
        tick();
        i_array_ack = 16'h0001;
        i_err_clear = 1'b1;
        tick();
        i_err_clear = 1'b0;
        checks++;
        if (o_aer_req !== 1'b1 || o_timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear_ignored: req=%b err=%b expected 1/0", o_aer_req, o_timeout_err);
        end
        repeat (8) tick();
        checks++;
        if (o_timeout_err !== 1'b0 || o_aer_req !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: err=%b req=%b at 9 cycles, expected 0/1", o_timeout_err, o_aer_req);
        end
        tick();
        checks++;
        if (o_timeout_err !== 1'b1 || o_aer_req !== 1'b0 || o_src_ack !== 3'b000 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_err: err=%b req=%b ack=%b busy=%b at 10 cycles, expected 1/0/000/1",
                     o_timeout_err, o_aer_req, o_src_ack, o_busy);
        end
        i_src_req   = 3'b000;
        i_array_ack = '0;
        tick();
        checks++;
        if (o_timeout_err !== 1'b1 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: err=%b busy=%b expected 1/1", o_timeout_err, o_busy);
        end
        i_err_clear = 1'b1;
        tick();
        i_err_clear = 1'b0;
        checks++;
        if (o_timeout_err !== 1'b0 || o_busy !== 1'b0 || o_event_count !== 16'd3) begin
            errors++;
            $display("FAIL timeout_cleared: err=%b busy=%b cnt=%0d expected 0/0/3", o_timeout_err, o_busy, o_event_count);
        end
        // rr pointer was left at 1 by the aborted grant, so src2 beats src0.
        set_src(0, 8'hA0, 10'd1);
        set_src(2, 8'h0F, 10'd1000);
        i_array_en = 16'h0001;
        i_src_req  = 3'b101;
        exp = rr_pick(3'b101, mptr);
        tick();
        checks++;
        if (o_aer_req !== 1'b1 || o_grant_id !== GID_W'(exp) || o_aer_time !== 8'h0F || o_aer_addr !== 10'd1000) begin
            errors++;
            $display("FAIL after_err_grant: req=%b id=%0d time=%h addr=%0d expected 1/%0d/0f/1000",
                     o_aer_req, o_grant_id, o_aer_time, o_aer_addr, exp);
        end
        i_array_ack = 16'h0001;
        tick();
        i_src_req   = 3'b001;
        i_array_ack = '0;
        tick();
        checks++;
        if (o_src_ack !== 3'b000 || o_event_count !== 16'd4) begin
            errors++;
            $display("FAIL after_err_done: ack=%b cnt=%0d expected 000/4", o_src_ack, o_event_count);
        end
        mptr = 0;
        tick();
        checks++;
        if (o_aer_req !== 1'b1 || o_grant_id !== 2'd0 || o_aer_time !== 8'hA0) begin
            errors++;
            $display("FAIL pending_grant: req=%b id=%0d time=%h expected 1/0/a0", o_aer_req, o_grant_id, o_aer_time);
        end
        i_array_ack = 16'h0001;
        tick();
        i_src_req   = 3'b000;
        i_array_ack = '0;
        tick();
        checks++;
        if (o_event_count !== 16'd5 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL pending_done: cnt=%0d busy=%b expected 5/0", o_event_count, o_busy);
        end
        mptr = 1;
        model_count = 5;
    endtask

    task automatic test_reset_mid();
        set_src(1, 8'h11, 10'd11);
        i_array_en = '0;
        i_src_req  = 3'b010;
        tick();
        tick();
        checks++;
        if (o_src_ack !== 3'b010) begin
            errors++;
            $display("FAIL reset_mid_setup: ack=%b expected 010", o_src_ack);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({o_aer_req, o_src_ack, o_aer_time, o_aer_addr, o_grant_id, o_busy, o_timeout_err, o_event_count} !== '0) begin
            errors++;
            $display("FAIL reset_mid: req=%b ack=%b id=%0d busy=%b cnt=%0d, all must be 0",
                     o_aer_req, o_src_ack, o_grant_id, o_busy, o_event_count);
        end
        rst       = 1'b0;
        i_src_req = 3'b000;
        tick();
        mptr = 0;
        model_count = 0;
    endtask

    // Runs source and array behaviour cycle by cycle and predicts every
    // DUT reaction from the arbitration rules. Starts and ends with the bus idle.
    task automatic run_traffic(input int n_events, input bit all_busy, input int max_cyc);
        logic [NUM_ARRAYS-1:0] lat;
        logic [NUM_SRC-1:0]    prev_ack;
        logic                  prev_req, agg_a, agg_i;
        int g, exp, done, cyc;
        lat = '0; prev_ack = '0; prev_req = 1'b0; g = 0; done = 0; cyc = 0;
        grant_log.delete();
        if (all_busy) i_array_en = '1;
        while (cyc < max_cyc && (done < n_events || i_src_req != '0 || o_busy)) begin
            tick();
            cyc++;
            agg_a = &(i_array_ack | ~lat);
            agg_i = ~|(i_array_ack & lat);
            checks++;
            if (o_timeout_err !== 1'b0 || $countones(o_src_ack) > 1) begin
                errors++;
                $display("FAIL traffic_sanity: err=%b ack=%b", o_timeout_err, o_src_ack);
            end
            checks++;
            if (prev_req) begin
                if (agg_a) begin
                    if (o_aer_req !== 1'b0 || o_src_ack !== onehot(g)) begin
                        errors++;
                        $display("FAIL traffic_ack: req=%b ack=%b expected 0/%b", o_aer_req, o_src_ack, onehot(g));
                    end
                end else if (o_aer_req !== 1'b1 || o_src_ack !== '0) begin
                    errors++;
                    $display("FAIL traffic_wait: req=%b ack=%b expected 1/000", o_aer_req, o_src_ack);
                end
            end else if (prev_ack != '0) begin
                if (agg_i && !i_src_req[g]) begin
                    model_count++;
                    mptr = (g + 1) % NUM_SRC;
                    done++;
                    if (o_src_ack !== '0 || o_event_count !== CNT_W'(model_count)) begin
                        errors++;
                        $display("FAIL traffic_release: ack=%b cnt=%0d expected 000/%0d", o_src_ack, o_event_count, model_count);
                    end
                end else if (o_src_ack !== prev_ack) begin
                    errors++;
                    $display("FAIL traffic_hold: ack=%b expected %b", o_src_ack, prev_ack);
                end
            end else if (i_src_req != '0) begin
                exp = rr_pick(i_src_req, mptr);
                if (o_aer_req !== 1'b1 || o_grant_id !== GID_W'(exp) || o_src_ack !== '0 ||
                    o_aer_time !== i_src_time[exp*TIME_W +: TIME_W] || o_aer_addr !== i_src_addr[exp*ADDR_W +: ADDR_W]) begin
                    errors++;
                    $display("FAIL traffic_grant: req=%b id=%0d time=%h addr=%0d expected 1/%0d/%h/%0d", o_aer_req,
                             o_grant_id, o_aer_time, o_aer_addr, exp, i_src_time[exp*TIME_W +: TIME_W], i_src_addr[exp*ADDR_W +: ADDR_W]);
                end
                g   = exp;
                lat = i_array_en;
                grant_log.push_back(int'(o_grant_id));
            end else if (o_aer_req !== 1'b0 || o_busy !== 1'b0) begin
                errors++;
                $display("FAIL traffic_idle: req=%b busy=%b expected 0/0", o_aer_req, o_busy);
            end
            prev_req = o_aer_req;
            prev_ack = o_src_ack;
            // Sources: four-phase, data held while req is high.
            for (int k = 0; k < NUM_SRC; k++) begin
                if (o_src_ack[k]) begin
                    if (all_busy || $urandom_range(0, 7) != 0) i_src_req[k] = 1'b0;
                end else if (!i_src_req[k] && done < n_events && (all_busy || $urandom_range(0, 2) == 0)) begin
                    set_src(k, TIME_W'($urandom), ADDR_W'($urandom));
                    i_src_req[k] = 1'b1;
                end
            end
            // Arrays: latched-enabled ones follow o_aer_req, others are noise.
            for (int j = 0; j < NUM_ARRAYS; j++) begin
                if (lat[j]) begin
                    if (o_aer_req && !i_array_ack[j] && (all_busy || $urandom_range(0, 7) != 0)) i_array_ack[j] = 1'b1;
                    else if (!o_aer_req && i_array_ack[j] && (all_busy || $urandom_range(0, 7) != 0)) i_array_ack[j] = 1'b0;
                end else begin
                    i_array_ack[j] = all_busy ? 1'b0 : 1'($urandom_range(0, 1));
                end
            end
            if (!all_busy) i_array_en = ($urandom_range(0, 3) == 0) ? '0 : NUM_ARRAYS'($urandom);
        end
        checks++;
        if (cyc >= max_cyc) begin
            errors++;
            $display("FAIL traffic_budget: %0d of %0d events after %0d cycles", done, n_events, cyc);
        end
        i_array_ack = '0;
        tick();
    endtask

    task automatic test_round_robin();
        run_traffic(6, 1'b1, 300);
        checks++;
        if (grant_log.size() < 6) begin
            errors++;
            $display("FAIL rr_len: %0d grants expected at least 6", grant_log.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (grant_log[i] != i % NUM_SRC) begin
                    errors++;
                    $display("FAIL rr_order[%0d]: got %0d expected %0d", i, grant_log[i], i % NUM_SRC);
                end
            end
        end
        checks++;
        if (o_event_count !== CNT_W'(model_count)) begin
            errors++;
            $display("FAIL rr_count: got %0d expected %0d", o_event_count, model_count);
        end
    endtask

    task automatic test_random();
        run_traffic(40, 1'b0, 4000);
        checks++;
        if (o_event_count !== CNT_W'(model_count) || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL random_count: cnt=%0d busy=%b expected %0d/0", o_event_count, o_busy, model_count);
        end
    endtask

    initial begin
        rst         = 1'b1;
        i_src_req   = '0;
        i_src_time  = '0;
        i_src_addr  = '0;
        i_array_en  = '0;
        i_array_ack = '0;
        i_err_clear = 1'b0;
        test_reset();
        test_single();
        test_partial_ack();
        test_empty_mask();
        test_timeout();
        test_reset_mid();
        test_round_robin();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aer_bus_arbiter.md
Name: aer_bus_arbiter

Overview:
- Shares the single AER broadcast bus (req/time/addr) feeding all SNN_Array_4PE instances between NUM_SRC event sources: GALS encoder, intermediate buffer encoder, host/debug injector.
- Round-robin grant; four-phase handshake on both sides; aggregates per-array acks over a latched enable mask; per-transaction watchdog raises a sticky error.
- Sits between the event sources and the array bank, replacing the per-state ack/req muxing in the engine FSM.

Parameters:
NUM_SRC, 3, number of requesting event sources
TIME_W, 8, spike time width (Q1.7)
ADDR_W, 10, AER address width
NUM_ARRAYS, 16, number of 4-PE arrays on the bus
TIMEOUT_CYC, 255, max cycles per handshake phase before error (>=2)
CNT_W, 16, width of delivered-event counter

Ports:
local_clk  in  1  sole clock
rst  in  1  synchronous, active-high reset
i_src_req  in  NUM_SRC  per-source event request (four-phase)
i_src_time  in  NUM_SRC*TIME_W  per-source spike time, src k at [k*TIME_W +: TIME_W]
i_src_addr  in  NUM_SRC*ADDR_W  per-source address, src k at [k*ADDR_W +: ADDR_W]
o_src_ack  out  NUM_SRC  per-source ack, one-hot or zero
i_array_en  in  NUM_ARRAYS  arrays participating (clock-enabled) for current layer
i_array_ack  in  NUM_ARRAYS  per-array AER ack
o_aer_req  out  1  broadcast request to arrays
o_aer_time  out  TIME_W  latched spike time
o_aer_addr  out  ADDR_W  latched address
o_grant_id  out  clog2(NUM_SRC) (min 1)  index of current/last granted source
o_busy  out  1  high in any state other than IDLE
o_timeout_err  out  1  sticky watchdog error
i_err_clear  in  1  clears error, returns to IDLE
o_event_count  out  CNT_W  events completed since reset, wraps at 2^CNT_W

Behaviour:
- Reset (rst high at posedge): state IDLE; all outputs 0; rr pointer 0; en_lat 0; watchdog 0. Overrides everything, including mid-transaction.
- agg_ack = &(i_array_ack | ~en_lat); agg_idle = ~|(i_array_ack & en_lat).
- IDLE: if any i_src_req, pick first requester scanning from rr pointer upward, wrapping. Latch time, addr, i_array_en into en_lat; set o_grant_id; go ISSUE. o_aer_req registered high next cycle, so req seen in cycle N gives o_aer_req high at N+1.
- ISSUE: o_aer_req=1, time/addr stable. When agg_ack: o_aer_req<=0, o_src_ack[g]<=1, go RELEASE. Ack sampled in cycle M drops req/raises src ack at M+1.
- RELEASE: hold o_src_ack[g]. When agg_idle and i_src_req[g]==0: o_src_ack<=0, o_event_count++, rr pointer <= g+1 (wrap to 0 past NUM_SRC-1), go IDLE. The next grant is earliest on the following cycle.
- en_lat==0: agg_ack and agg_idle are both vacuously true. The event is consumed and dropped with minimum latency, and it is still counted.
- i_array_en changes during a transaction do not affect it; only en_lat is used.
- Non-granted requests are held pending, never acked. A requester dropping req before grant is legal and ignored.
- Watchdog: cleared on entering ISSUE or RELEASE; increments each cycle in those states. On reaching TIMEOUT_CYC, go ERR.
- ERR: o_aer_req=0, o_src_ack=0, o_timeout_err=1, o_busy=1. Stays until i_err_clear, then returns to IDLE with o_timeout_err<=0 and rr pointer unchanged. i_err_clear in other states is ignored.
- Source obligation: time/addr held stable while req high. The arbiter latches at grant and never re-samples.
- Fairness: with all NUM_SRC requesting continuously, grant order is 0,1,2,0,… with no source starved beyond NUM_SRC-1 other grants.

Test Plan:
- Single event: src1 req, time=8'h14, addr=10'd37, en=16'h00FF; arrays 0-7 ack 2 cycles after o_aer_req → o_aer_req rises 1 cycle after req, o_aer_time=8'h14/addr=37 stable, o_src_ack[1] rises 1 cycle after last array ack, o_event_count=1, o_grant_id=1.
- Round-robin: all 3 sources hold req for 6 events, arrays ack immediately → grant sequence 0,1,2,0,1,2; o_event_count=6; never two o_src_ack bits high.
- Partial ack: en=16'h0001 (D3 config), arrays 1-15 never ack → transaction completes on array 0 ack alone; flipping i_array_en to 16'hFFFF mid-ISSUE has no effect.
- Empty mask: en=0, src0 req → src ack in 2 cycles after grant, no dependency on i_array_ack, count increments.
- Timeout: TIMEOUT_CYC=10, one enabled array never acks → o_timeout_err=1 exactly 10 cycles after ISSUE entry, o_aer_req=0; i_err_clear → IDLE, err low, next request served normally.
- Reset mid-RELEASE with o_src_ack high → next cycle all outputs 0, state IDLE, count 0, rr pointer 0.
